// File: rtl/adder_serial_nbit.sv
// Multi-cycle adder: DIGIT bits per clock through a registered carry.
// Optional subtract mode under ADDER_SUB_EN (adds port sub).
module adder_serial_nbit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] Sum,
  output logic             C4,
  output logic             V,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad
      $error("adder_serial_nbit: bad WIDTH/DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] bload;
  logic             cload;

`ifdef ADDER_SUB_EN
  // two's complement subtract: A + ~B + 1
  assign bload = sub ? ~B : B;
  assign cload = sub ? 1'b1 : C0;
`else
  assign bload = B;
  assign cload = C0;
`endif

  logic [DIGIT-1:0] dsum;
  logic             dcout;
  logic             dcmsb;
  logic             cc;

  // dcmsb is the carry into the top bit of this digit
  always_comb begin
    cc    = carry;
    dsum  = '0;
    dcmsb = carry;
    for (int i = 0; i < DIGIT; i++) begin
      dcmsb   = cc;
      dsum[i] = areg[i] ^ breg[i] ^ cc;
      cc      = (areg[i] & breg[i])
              | (cc & (areg[i] ^ breg[i]));
    end
    dcout = cc;
  end

  logic [WIDTH-1:0] sum_nxt;

  assign sum_nxt = (Sum >> DIGIT)
                 | (WIDTH'(dsum) << (WIDTH - DIGIT));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      areg  <= '0;
      breg  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      Sum   <= '0;
      C4    <= 1'b0;
      V     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            areg  <= A;
            breg  <= bload;
            carry <= cload;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          Sum   <= sum_nxt;
          areg  <= areg >> DIGIT;
          breg  <= breg >> DIGIT;
          carry <= dcout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            C4    <= dcout;
            V     <= dcmsb ^ dcout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_serial_nbit.sv
// Directed bench for adder_serial_nbit: 8-bit/2-digit and 4-bit/4-digit.
// Subtract vectors run only when ADDER_SUB_EN is defined.
module tb_adder_serial_nbit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       C0;
  logic       sub;
  logic [7:0] Sum;
  logic       C4;
  logic       V;
  logic       busy;
  logic       done;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       c04;
  logic       sub4;
  logic [3:0] sum4;
  logic       c44;
  logic       v4;
  logic       busy4;
  logic       done4;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  adder_serial_nbit #(.WIDTH(8), .DIGIT(2)) dut (
    .clock (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .C0    (C0),
`ifdef ADDER_SUB_EN
    .sub   (sub),
`endif
    .Sum   (Sum),
    .C4    (C4),
    .V     (V),
    .busy  (busy),
    .done  (done)
  );

  adder_serial_nbit #(.WIDTH(4), .DIGIT(4)) dut4 (
    .clock (clk),
    .reset (reset),
    .start (start4),
    .A     (a4),
    .B     (b4),
    .C0    (c04),
`ifdef ADDER_SUB_EN
    .sub   (sub4),
`endif
    .Sum   (sum4),
    .C4    (c44),
    .V     (v4),
    .busy  (busy4),
    .done  (done4)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic launch8(input logic [7:0] a,
                         input logic [7:0] b,
                         input logic c0,
                         input logic sb);
    @(negedge clk);
    A = a; B = b; C0 = c0; sub = sb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = ~a; B = ~b; C0 = ~c0; sub = ~sb;
    check("busy_start", busy, 1);
  endtask

  task automatic wait8(input string tag,
                       input logic [7:0] es,
                       input logic ec,
                       input logic ev);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 20);
    check({tag, "_lat"}, n, 4);
    check({tag, "_sum"}, Sum, es);
    check({tag, "_c4"}, C4, ec);
    check({tag, "_v"}, V, ev);
    check({tag, "_busy"}, busy, 0);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, done, 0);
    check({tag, "_hold"}, Sum, es);
  endtask

  task automatic op4(input string tag,
                     input logic [3:0] a,
                     input logic [3:0] b,
                     input logic c0,
                     input logic [3:0] es,
                     input logic ec);
    int n;
    @(negedge clk);
    a4 = a; b4 = b; c04 = c0;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    a4 = ~a; b4 = ~b;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done4 && n < 10);
    check({tag, "_lat"}, n, 1);
    check({tag, "_sum"}, sum4, es);
    check({tag, "_c4"}, c44, ec);
    check({tag, "_v"}, v4, 0);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, done4, 0);
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    start = 1'b0; A = '0; B = '0; C0 = 1'b0; sub = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; c04 = 1'b0; sub4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum", Sum, 0);
    check("rst_flags", {C4, V, busy, done}, 0);
    check("rst4", {sum4, c44, v4, busy4, done4}, 0);
    @(negedge clk);
    reset = 1'b0;

    launch8(8'hAA, 8'h55, 1'b0, 1'b0);
    wait8("aa55", 8'hFF, 1'b0, 1'b0);
    launch8(8'hAA, 8'h55, 1'b1, 1'b0);
    wait8("aa55c", 8'h00, 1'b1, 1'b0);
    launch8(8'h7F, 8'h01, 1'b0, 1'b0);
    wait8("ovf", 8'h80, 1'b0, 1'b1);
    launch8(8'hFF, 8'h01, 1'b0, 1'b0);
    wait8("wrap", 8'h00, 1'b1, 1'b0);

    // start during RUN is ignored, then accepted in IDLE
    launch8(8'hAA, 8'h55, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; A = 8'h11; B = 8'h22; C0 = 1'b0; sub = 1'b0;
    wait8("ign", 8'hFF, 1'b0, 1'b0);
    check("ign_idle", busy, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign_accept", busy, 1);
    wait8("next", 8'h33, 1'b0, 1'b0);

    // reset at edge 2 of RUN with start high
    launch8(8'h7F, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    A = 8'h11; B = 8'h22;
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0;
    check("abort_sum", Sum, 0);
    check("abort_flags", {C4, V, busy, done}, 0);
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    check("abort_quiet", seen, 0);
    launch8(8'h7F, 8'h01, 1'b0, 1'b0);
    wait8("fresh", 8'h80, 1'b0, 1'b1);

    op4("w4a", 4'hA, 4'h5, 1'b0, 4'hF, 1'b0);
    op4("w4b", 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
    op4("w4c", 4'h5, 4'hA, 1'b0, 4'hF, 1'b0);
    op4("w4d", 4'hA, 4'h5, 1'b1, 4'h0, 1'b1);

`ifdef ADDER_SUB_EN
    launch8(8'h05, 8'h0A, 1'b0, 1'b1);
    wait8("sub1", 8'hFB, 1'b0, 1'b0);
    launch8(8'h80, 8'h01, 1'b0, 1'b1);
    wait8("sub2", 8'h7F, 1'b1, 1'b1);
    launch8(8'h7F, 8'h01, 1'b0, 1'b0);
    wait8("sub0", 8'h80, 1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             nchk, nerr);
    $finish;
  end

endmodule
